number_entry: RTL

Decimal operand-entry unit: the input-side counterpart of the seven-segment display path. It turns decimal key/switch strobes into an 8-bit two's-complement value for the ARM single-cycle datapath's memory-mapped I/O. The user enters up to three digits and a sign, then commits. The block also exposes the in-progress entry as BCD so the display path can echo it.

---
 rtl/entry_pkg.sv | 38 +++
 rtl/rise_detect.sv | 28 ++
 rtl/number_entry.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/entry_pkg.sv
// Shared types, limits and the binary-to-BCD helper for the decimal operand-entry unit.
package entry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } entry_state_t;

  localparam logic [9:0] MAX_POS     = 10'd127;
  localparam logic [9:0] MAX_NEG_MAG = 10'd128;
  localparam logic [1:0] MAX_DIGITS  = 2'd3;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  function automatic bcd_t to_bcd(input logic [7:0] v);
    bcd_t       b;
    logic [7:0] r;
    if (v >= 8'd200) begin
      b.hund = 4'd2;
      r      = v - 8'd200;
    end else if (v >= 8'd100) begin
      b.hund = 4'd1;
      r      = v - 8'd100;
    end else begin
      b.hund = 4'd0;
      r      = v;
    end
    b.tens  = 4'(r / 8'd10);
    b.units = 4'(r % 8'd10);
    return b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector; the history flop clears on reset.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  // Next history value is simply the current input level.
  always_comb begin
    prev_d = d;
  end

  // Input history register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/number_entry.sv
// Decimal operand-entry unit: builds a signed 8-bit value from digit/sign/enter/clear
// key strobes and echoes the in-progress magnitude as BCD.
module number_entry
  import entry_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       digit_key,
  input  logic       sign_key,
  input  logic       enter_key,
  input  logic       clear_key,
  output logic [7:0] num,
  output logic       num_valid,
  output logic       cur_neg,
  output logic [3:0] cur_hund,
  output logic [3:0] cur_tens,
  output logic [3:0] cur_units,
  output logic [1:0] ndigits,
  output logic       err
);

  logic dig_p, sgn_p, ent_p, clr_p;

  rise_detect u_dig (.clk(clk), .reset(reset), .d(digit_key), .pulse(dig_p));
  rise_detect u_sgn (.clk(clk), .reset(reset), .d(sign_key),  .pulse(sgn_p));
  rise_detect u_ent (.clk(clk), .reset(reset), .d(enter_key), .pulse(ent_p));
  rise_detect u_clr (.clk(clk), .reset(reset), .d(clear_key), .pulse(clr_p));

  entry_state_t state_q, state_d;
  logic [7:0]   mag_q, mag_d;
  logic         neg_q, neg_d;
  logic [1:0]   nd_q, nd_d;
  logic         err_q, err_d;
  logic [7:0]   num_q, num_d;
  logic         num_valid_q, num_valid_d;

  logic [7:0]   base_mag;
  logic         base_neg;
  logic [1:0]   base_nd;
  logic [9:0]   cand;
  logic [9:0]   limit;
  logic         dig_ok;
  bcd_t         bcd_s;

  // Next-state logic: one request per cycle, clear > enter > sign > digit.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    nd_d        = nd_q;
    err_d       = err_q;
    num_d       = num_q;
    num_valid_d = 1'b0;

    // A digit after a commit starts over from an empty entry in the same cycle.
    if (state_q == DONE) begin
      base_mag = 8'd0;
      base_neg = 1'b0;
      base_nd  = 2'd0;
    end else begin
      base_mag = mag_q;
      base_neg = neg_q;
      base_nd  = nd_q;
    end
    cand   = ({2'b00, base_mag} << 3) + ({2'b00, base_mag} << 1) + {6'd0, digit};
    limit  = base_neg ? MAX_NEG_MAG : MAX_POS;
    dig_ok = (digit <= 4'd9) && (base_nd < MAX_DIGITS) && (cand <= limit);

    if (clr_p) begin
      state_d = IDLE;
      mag_d   = 8'd0;
      neg_d   = 1'b0;
      nd_d    = 2'd0;
      err_d   = 1'b0;
    end else if (ent_p) begin
      if (state_q == ENTRY) begin
        num_d       = neg_q ? (~mag_q + 8'd1) : mag_q;
        num_valid_d = 1'b1;
        err_d       = 1'b0;
        state_d     = DONE;
      end else begin
        err_d = 1'b1;
      end
    end else if (sgn_p) begin
      case (state_q)
        DONE: begin
          state_d = IDLE;
          mag_d   = 8'd0;
          neg_d   = 1'b1;
          nd_d    = 2'd0;
        end
        IDLE, ENTRY: begin
          if (neg_q && ({2'b00, mag_q} == MAX_NEG_MAG)) begin
            err_d = 1'b1;
          end else begin
            neg_d = ~neg_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (dig_p) begin
      if (dig_ok) begin
        mag_d   = cand[7:0];
        neg_d   = base_neg;
        nd_d    = base_nd + 2'd1;
        err_d   = 1'b0;
        state_d = ENTRY;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      num_valid_d = 1'b0;
    end
  end

  // State and output registers; reset also zeroes the committed value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mag_q       <= 8'd0;
      neg_q       <= 1'b0;
      nd_q        <= 2'd0;
      err_q       <= 1'b0;
      num_q       <= 8'd0;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      nd_q        <= nd_d;
      err_q       <= err_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
    end
  end

  assign bcd_s     = to_bcd(mag_q);
  assign cur_hund  = bcd_s.hund;
  assign cur_tens  = bcd_s.tens;
  assign cur_units = bcd_s.units;
  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign cur_neg   = neg_q;
  assign ndigits   = nd_q;
  assign err       = err_q;

endmodule
